// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and owner constants for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way picker.
// Round-robin on last_owner when DMEM_ARB_RR_EN is defined, fixed A-over-B priority otherwise.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_owner,
    output logic valid,
    output logic owner
);
    assign valid = a_req | b_req;
`ifdef DMEM_ARB_RR_EN
    assign owner = (a_req & b_req) ? ~last_owner : (b_req ? OWNER_B : OWNER_A);
`else
    logic w_unused;
    assign w_unused = last_owner;
    assign owner = a_req ? OWNER_A : OWNER_B;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters onto a single-port data memory and routes read data back.
// Define DMEM_ARB_RR_EN for round-robin arbitration; fixed A-over-B priority otherwise.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WIDTH    = 32,
    parameter int MEM_SIZE     = 256,
    parameter int READ_LATENCY = 1,
    localparam int AW          = $clog2(MEM_SIZE)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val
);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("dmem_arbiter: READ_LATENCY must be >= 1");
    end

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_owner, r_we;
    logic [AW-1:0]        r_addr;
    logic [MEM_WIDTH-1:0] r_wdata, r_a_rdata, r_b_rdata;
    logic                 w_pick_valid, w_pick_owner, w_last, w_issue, w_done;

`ifdef DMEM_ARB_RR_EN
    logic r_last;
    // Out of reset B counts as last granted, so A is favoured first
    always_ff @(posedge clk) begin
        if (rst) r_last <= OWNER_B;
        else if (w_issue) r_last <= r_owner;
    end
    assign w_last = r_last;
`else
    assign w_last = OWNER_A;
`endif

    dmem_arb_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_owner (w_last),
        .valid      (w_pick_valid),
        .owner      (w_pick_owner)
    );

    always_comb begin
        w_issue       = r_state == ISSUE;
        w_done        = r_state == WAIT && r_cnt == '0;
        w_state       = r_state == IDLE ? (w_pick_valid ? ISSUE : IDLE)
                      : w_issue ? (r_we ? IDLE : WAIT)
                      : (r_state == WAIT && !w_done) ? WAIT : IDLE;
        a_gnt         = w_issue && r_owner == OWNER_A;
        b_gnt         = w_issue && r_owner == OWNER_B;
        a_rvalid      = w_done && r_owner == OWNER_A;
        b_rvalid      = w_done && r_owner == OWNER_B;
        a_rdata       = a_rvalid ? mem_read_val : r_a_rdata;
        b_rdata       = b_rvalid ? mem_read_val : r_b_rdata;
        mem_addr      = r_state == IDLE ? '0 : r_addr;
        mem_read_en   = w_issue && !r_we;
        mem_write_en  = w_issue && r_we;
        mem_write_val = mem_write_en ? r_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_owner   <= OWNER_A;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_state <= w_state;
            if (r_state == IDLE && w_pick_valid) begin
                r_owner <= w_pick_owner;
                r_we    <= w_pick_owner == OWNER_B ? b_we : a_we;
                r_addr  <= w_pick_owner == OWNER_B ? b_addr : a_addr;
                r_wdata <= w_pick_owner == OWNER_B ? b_wdata : a_wdata;
            end
            if (w_issue) r_cnt <= CW'(READ_LATENCY - 1);
            else if (r_state == WAIT) r_cnt <= r_cnt - CW'(1);
            if (a_rvalid) r_a_rdata <= mem_read_val;
            if (b_rvalid) r_b_rdata <= mem_read_val;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector bench for dmem_arbiter with a small latency-accurate memory model.
module tb_dmem_arbiter;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_read_en, mem_write_en;
    logic [31:0] a_rdata, b_rdata, mem_write_val, mem_read_val;
    logic [7:0]  mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val)
    );

    // Memory model: read data appears LAT cycles after the strobe, junk otherwise
    logic [31:0] mem [256];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_write_val;
        pipe[0] <= mem_read_en ? mem[mem_addr] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_read_val = pipe[LAT-1];

    int n_ag = 0, n_bg = 0, n_av = 0, n_bv = 0, n_ren = 0;
    always @(posedge clk) begin
        n_ag  <= n_ag + int'(a_gnt);
        n_bg  <= n_bg + int'(b_gnt);
        n_av  <= n_av + int'(a_rvalid);
        n_bv  <= n_bv + int'(b_rvalid);
        n_ren <= n_ren + int'(mem_read_en);
    end

    int   n_chk = 0, n_fail = 0;
    logic last_owner = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic first_of(input logic last);
`ifdef DMEM_ARB_RR_EN
        return !last;
`else
        return 1'b0 & last;
`endif
    endfunction

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic run_txn(input vec_t v);
        int c;
        int s_ag, s_bg, s_av, s_bv, s_ren;
        @(negedge clk);
        s_ag = n_ag; s_bg = n_bg; s_av = n_av; s_bv = n_bv; s_ren = n_ren;
        if (v.port) begin
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
        end
        c = 0;
        do begin @(negedge clk); c++; end while (!(v.port ? b_gnt : a_gnt) && c < 20);
        chk("txn_req_to_gnt", 32'(c), 32'd1);
        chk("txn_mem_write_en", 32'(mem_write_en), 32'(v.we));
        chk("txn_mem_read_en", 32'(mem_read_en), 32'(!v.we));
        chk("txn_mem_addr", 32'(mem_addr), 32'(v.addr));
        chk("txn_mem_write_val", mem_write_val, v.we ? v.wdata : 32'h0);
        a_req = 1'b0; b_req = 1'b0;
        if (!v.we) begin
            c = 0;
            do begin @(negedge clk); c++; end while (!(v.port ? b_rvalid : a_rvalid) && c < 20);
            chk("txn_gnt_to_rvalid", 32'(c), 32'(LAT));
            chk("txn_rdata", v.port ? b_rdata : a_rdata, v.exp);
        end
        @(negedge clk);
        if (!v.we) chk("txn_rdata_hold", v.port ? b_rdata : a_rdata, v.exp);
        chk("txn_a_gnt_count", 32'(n_ag - s_ag), 32'(!v.port));
        chk("txn_b_gnt_count", 32'(n_bg - s_bg), 32'(v.port));
        chk("txn_a_rvalid_count", 32'(n_av - s_av), 32'(!v.port && !v.we));
        chk("txn_b_rvalid_count", 32'(n_bv - s_bv), 32'(v.port && !v.we));
        chk("txn_read_en_count", 32'(n_ren - s_ren), 32'(!v.we));
        last_owner = v.port;
    endtask

    task automatic dual_read();
        int ga = 0, gb = 0, va = 0, vb = 0;
        int t_a, t_b;
        logic [31:0] da = '0, db = '0;
        logic first;
        first = first_of(last_owner);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        for (int c = 1; c <= 4 * LAT + 8; c++) begin
            @(negedge clk);
            if (a_gnt) begin ga = c; a_req = 1'b0; end
            if (b_gnt) begin gb = c; b_req = 1'b0; end
            if (a_rvalid) begin va = c; da = a_rdata; end
            if (b_rvalid) begin vb = c; db = b_rdata; end
        end
        t_a = first ? LAT + 3 : 1;
        t_b = first ? 1 : LAT + 3;
        chk("dual_a_gnt_cycle", 32'(ga), 32'(t_a));
        chk("dual_b_gnt_cycle", 32'(gb), 32'(t_b));
        chk("dual_a_rvalid_cycle", 32'(va), 32'(t_a + LAT));
        chk("dual_b_rvalid_cycle", 32'(vb), 32'(t_b + LAT));
        chk("dual_a_rdata", da, 32'h11111111);
        chk("dual_b_rdata", db, 32'h22222222);
        last_owner = !first;
    endtask

    task automatic cont_writes();
        int g = 0, c = 0, na = 0, nb = 0;
        logic exp_o;
        exp_o = first_of(last_owner);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 32'hAAAA0001;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h21; b_wdata = 32'hBBBB0002;
        while (g < 8 && c < 60) begin
            @(negedge clk);
            c++;
            if (a_gnt || b_gnt) begin
                chk("cont_onehot", 32'(a_gnt && b_gnt), 32'd0);
                chk("cont_owner", 32'(b_gnt), 32'(exp_o));
                if (b_gnt) nb++; else na++;
                last_owner = b_gnt;
                exp_o = first_of(last_owner);
                g++;
                if (g == 8) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        chk("cont_grants", 32'(g), 32'd8);
        chk("cont_last_gnt_cycle", 32'(c), 32'd15);
`ifdef DMEM_ARB_RR_EN
        chk("cont_a_share", 32'(na), 32'd4);
        chk("cont_b_share", 32'(nb), 32'd4);
`else
        chk("cont_a_share", 32'(na), 32'd8);
        chk("cont_b_share", 32'(nb), 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s_av, s_bv, s_ag, s_bg, bad;
        vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 8'h7F, 32'h12345678, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 8'h7F, 32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 32'hFFFFFFFF, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 32'h0,        32'hFFFFFFFF};
        vecs[8] = '{1'b0, 1'b1, 8'h01, 32'h11111111, 32'h0};
        vecs[9] = '{1'b1, 1'b1, 8'h02, 32'h22222222, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_mem_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_write_val", mem_write_val, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i]);
        dual_read();
        cont_writes();

        // Abort an A read in its first WAIT cycle
        @(negedge clk);
        s_av = n_av; s_bv = n_bv;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        @(negedge clk);
        chk("abort_gnt", 32'(a_gnt), 32'd1);
        a_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_a_rdata", a_rdata, 32'h0);
        chk("abort_b_rdata", b_rdata, 32'h0);
        chk("abort_mem_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_mem_write_val", mem_write_val, 32'h0);
        repeat (LAT + 3) @(negedge clk);
        chk("abort_no_a_rvalid", 32'(n_av - s_av), 32'd0);
        chk("abort_no_b_rvalid", 32'(n_bv - s_bv), 32'd0);
        last_owner = 1'b1;
        run_txn('{1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF});

        // Quiet bus
        s_ag = n_ag; s_bg = n_bg; s_av = n_av; s_bv = n_bv; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_read_en || mem_write_en || mem_write_val != 32'h0) bad++;
        end
        chk("idle_mem_quiet", 32'(bad), 32'd0);
        chk("idle_no_pulses", 32'((n_ag - s_ag) + (n_bg - s_bg) + (n_av - s_av) + (n_bv - s_bv)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
